// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, control-bit indices and state encoding for cpu_sequencer
package cpu_pkg;

    localparam logic [7:0] OPC_NOP    = 8'h00;
    localparam logic [7:0] OPC_STORE  = 8'h01;
    localparam logic [7:0] OPC_LOAD   = 8'h02;
    localparam logic [7:0] OPC_ADD    = 8'h03;
    localparam logic [7:0] OPC_SUB    = 8'h04;
    localparam logic [7:0] OPC_JMPGEZ = 8'h05;
    localparam logic [7:0] OPC_JMP    = 8'h06;
    localparam logic [7:0] OPC_HALT   = 8'h07;

    localparam int CB_MAR_PC   = 0;
    localparam int CB_MBR_MEM  = 1;
    localparam int CB_IR_MBR   = 2;
    localparam int CB_MAR_MBR  = 3;
    localparam int CB_MEM_MBR  = 4;
    localparam int CB_MBR_ACC  = 5;
    localparam int CB_PC_INC   = 6;
    localparam int CB_ACC_LD   = 7;
    localparam int CB_ACC_ADD  = 8;
    localparam int CB_ACC_SUB  = 9;
    localparam int CB_PC_LD    = 20;

    typedef enum logic [3:0] {
        S_FETCH1 = 4'd0,
        S_FETCH2 = 4'd1,
        S_FETCH3 = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC1  = 4'd4,
        S_EXEC2  = 4'd5,
        S_HALT   = 4'd6
    } state_t;

    // Instructions that read memory in EXEC1 (and so may wait there).
    function automatic logic is_read_op(input logic [7:0] op);
        return (op == OPC_LOAD) || (op == OPC_ADD) || (op == OPC_SUB);
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_read_op(op) || (op == OPC_STORE);
    endfunction

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational state/opcode to control word decode; MEM_WAIT_EN gates the PC increment on mem_ready
import cpu_pkg::*;

module seq_decode #(
    parameter int OP_W = 8
) (
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    input  logic            acc_neg,
    input  logic            mem_ready,
    output logic [31:0]     control_signal
);

    logic [7:0] op8;
    logic       mem_ok;

    assign op8 = 8'(opcode);

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        control_signal = 32'h0;
        case (state)
            S_FETCH1: control_signal[CB_MAR_PC] = 1'b1;
            S_FETCH2: begin
                // PC increments only on the cycle the fetch actually completes.
                control_signal[CB_MBR_MEM] = 1'b1;
                control_signal[CB_PC_INC]  = mem_ok;
            end
            S_FETCH3: control_signal[CB_IR_MBR] = 1'b1;
            S_DECODE: begin
                if (is_mem_op(op8))
                    control_signal[CB_MAR_MBR] = 1'b1;
                else if (op8 == OPC_JMP)
                    control_signal[CB_PC_LD] = 1'b1;
                else if (op8 == OPC_JMPGEZ)
                    control_signal[CB_PC_LD] = ~acc_neg;
            end
            S_EXEC1: begin
                if (is_read_op(op8))
                    control_signal[CB_MBR_MEM] = 1'b1;
                else if (op8 == OPC_STORE)
                    control_signal[CB_MBR_ACC] = 1'b1;
            end
            S_EXEC2: begin
                case (op8)
                    OPC_LOAD:  control_signal[CB_ACC_LD]  = 1'b1;
                    OPC_ADD:   control_signal[CB_ACC_ADD] = 1'b1;
                    OPC_SUB:   control_signal[CB_ACC_SUB] = 1'b1;
                    OPC_STORE: control_signal[CB_MEM_MBR] = 1'b1;
                    default:   control_signal = 32'h0;
                endcase
            end
            default: control_signal = 32'h0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - instruction sequencer state register and next-state logic; MEM_WAIT_EN adds memory wait states
import cpu_pkg::*;

module cpu_sequencer #(
    parameter int OP_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir_in,
    input  logic        acc_neg,
    input  logic        mem_ready,
    output logic [31:0] control_signal,
    output logic        halted,
    output logic [3:0]  state_dbg
);

    state_t          state;
    logic [OP_W-1:0] opcode;
    logic [7:0]      op8;
    logic            mem_ok;
    logic            unused_operand;

    assign opcode         = ir_in[15 -: OP_W];
    assign op8            = 8'(opcode);
    assign unused_operand = ^ir_in[7:0];
    assign state_dbg      = state;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_FETCH1;
            halted <= 1'b0;
        end else begin
            case (state)
                S_FETCH1: state <= S_FETCH2;
                S_FETCH2: if (mem_ok) state <= S_FETCH3;
                S_FETCH3: state <= S_DECODE;
                S_DECODE: begin
                    if (is_mem_op(op8)) begin
                        state <= S_EXEC1;
                    end else if (op8 == OPC_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_FETCH1;
                    end
                end
                S_EXEC1: if (mem_ok || !is_read_op(op8)) state <= S_EXEC2;
                S_EXEC2: if (mem_ok || op8 != OPC_STORE) state <= S_FETCH1;
                // HALT is left only through reset.
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH1;
            endcase
        end
    end

    seq_decode #(.OP_W(OP_W)) u_decode (
        .state          (state),
        .opcode         (opcode),
        .acc_neg        (acc_neg),
        .mem_ready      (mem_ready),
        .control_signal (control_signal)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ir_in = 16'h0000;
    logic        acc_neg = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] control_signal;
    logic        halted;
    logic [3:0]  state_dbg;

    int total = 0;
    int bad = 0;
    int pc_inc_count = 0;
    int pc_before;
    logic both_pc = 1'b0;
    logic arith_seen = 1'b0;
    logic arith_mon = 1'b0;
    logic halt_ok;

    logic [31:0] ev [8];
    logic [3:0]  es [8];

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .ir_in          (ir_in),
        .acc_neg        (acc_neg),
        .mem_ready      (mem_ready),
        .control_signal (control_signal),
        .halted         (halted),
        .state_dbg      (state_dbg)
    );

    always @(negedge clk) begin
        if (control_signal[6]) pc_inc_count++;
        if (control_signal[6] && control_signal[20]) both_pc = 1'b1;
        if (arith_mon && control_signal[9:8] != 2'b00) arith_seen = 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts in FETCH1; ev/es hold expected control word and state per cycle.
    task automatic run_seq(input string tag, input logic [15:0] ir, input logic neg, input int n);
        ir_in   = ir;
        acc_neg = neg;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s ctl[%0d]", tag, i), control_signal, ev[i]);
            chk($sformatf("%s st[%0d]", tag, i), 32'(state_dbg), 32'(es[i]));
            if (i < n - 1) tick();
        end
    endtask

    initial begin
        #2;
        chk("reset ctl", control_signal, 32'h1);
        chk("reset halted", 32'(halted), 32'h0);
        chk("reset state", 32'(state_dbg), 32'h0);
        tick();
        tick();
        chk("reset held state", 32'(state_dbg), 32'h0);
        rst = 1'b0;

        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0};
        pc_before = pc_inc_count;
        ev = '{32'h1, 32'h42, 32'h4, 32'h8, 32'h2, 32'h80, 32'h1, 32'h0};
        run_seq("load", 16'h0210, 1'b0, 7);
        chk("load pc_inc once", 32'(pc_inc_count - pc_before), 32'd1);

        ev = '{32'h1, 32'h42, 32'h4, 32'h8, 32'h2, 32'h100, 32'h1, 32'h0};
        run_seq("add", 16'h0310, 1'b0, 7);
        ev = '{32'h1, 32'h42, 32'h4, 32'h8, 32'h2, 32'h200, 32'h1, 32'h0};
        run_seq("sub", 16'h0410, 1'b1, 7);
        ev = '{32'h1, 32'h42, 32'h4, 32'h8, 32'h20, 32'h10, 32'h1, 32'h0};
        run_seq("store", 16'h0110, 1'b0, 7);

        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
        ev = '{32'h1, 32'h42, 32'h4, 32'h0010_0000, 32'h1, 32'h0, 32'h0, 32'h0};
        run_seq("jmp", 16'h0635, 1'b0, 5);
        ev = '{32'h1, 32'h42, 32'h4, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0};
        run_seq("jmpgez neg", 16'h0540, 1'b1, 5);
        ev = '{32'h1, 32'h42, 32'h4, 32'h0010_0000, 32'h1, 32'h0, 32'h0, 32'h0};
        run_seq("jmpgez pos", 16'h0540, 1'b0, 5);
        ev = '{32'h1, 32'h42, 32'h4, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0};
        run_seq("nop", 16'h0000, 1'b0, 5);
        run_seq("undef op", 16'h9A33, 1'b1, 5);

`ifdef MEM_WAIT_EN
        mem_ready = 1'b0;
        ir_in = 16'h0210;
        pc_before = pc_inc_count;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wait fetch2 ctl[%0d]", i), control_signal, 32'h2);
            chk($sformatf("wait fetch2 st[%0d]", i), 32'(state_dbg), 32'h1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("wait fetch2 release", control_signal, 32'h42);
        tick();
        chk("wait fetch3", 32'(state_dbg), 32'h2);
        chk("wait pc_inc once", 32'(pc_inc_count - pc_before), 32'd1);
        tick();
        tick();
        tick();
        tick();
        chk("wait back fetch1", 32'(state_dbg), 32'h0);
`else
        mem_ready = 1'b0;
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0};
        ev = '{32'h1, 32'h42, 32'h4, 32'h8, 32'h2, 32'h80, 32'h1, 32'h0};
        run_seq("mem_ready ignored", 16'h0210, 1'b0, 7);
        mem_ready = 1'b1;
`endif

        ir_in = 16'h0310;
        arith_mon = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("add exec1 state", 32'(state_dbg), 32'h4);
        chk("add exec1 ctl", control_signal, 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst ctl", control_signal, 32'h1);
        chk("async rst state", 32'(state_dbg), 32'h0);
        tick();
        rst = 1'b0;
        arith_mon = 1'b0;
        chk("no arith after abort", 32'(arith_seen), 32'h0);
        tick();
        chk("post rst fetch2", 32'(state_dbg), 32'h1);
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("post rst back fetch1", 32'(state_dbg), 32'h0);

        ir_in = 16'h0700;
        tick();
        tick();
        tick();
        chk("halt decode ctl", control_signal, 32'h0);
        chk("halt decode halted", 32'(halted), 32'h0);
        tick();
        chk("halt after 4", 32'(halted), 32'h1);
        chk("halt state", 32'(state_dbg), 32'h6);
        halt_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (control_signal !== 32'h0 || halted !== 1'b1) halt_ok = 1'b0;
            tick();
        end
        chk("halt stays 20", 32'(halt_ok), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("halt rst ctl", control_signal, 32'h1);
        chk("halt rst halted", 32'(halted), 32'h0);
        chk("halt rst state", 32'(state_dbg), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("halt rst fetch2", 32'(state_dbg), 32'h1);
        chk("halt rst fetch2 ctl", control_signal, 32'h42);

        chk("bits 6 and 20 exclusive", 32'(both_pc), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter OP_W, default 8: opcode width, taken from ir_in[15:8].
REQ-002 SHALL have clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ir_in  input  16  instruction register contents; opcode = ir_in[15:8], operand address = ir_in[7:0].
REQ-005 SHALL have acc_neg  input  1  accumulator sign bit, 1 = negative.
REQ-006 SHALL have mem_ready  input  1  memory access complete; used only under MEM_WAIT_EN.
REQ-007 SHALL have control_signal  output  32  datapath control word.
REQ-008 SHALL have halted  output  1  high while in HALT.
REQ-009 SHALL have state_dbg  output  4  current state encoding.

Function
REQ-010 Control bits SHALL be: 0 MAR<-PC, 1 MBR<-mem, 2 IR<-MBR, 3 MAR<-MBR[7:0], 4 mem<-MBR, 5 MBR<-ACC, 6 PC+1, 7 ACC<-MBR, 8 ACC+=MBR, 9 ACC-=MBR, 20 PC<-MBR[7:0]; all others always 0.
REQ-011 States SHALL be FETCH1, FETCH2, FETCH3, DECODE, EXEC1, EXEC2, HALT.
REQ-012 control_signal SHALL be a combinational function of state, opcode, acc_neg and (under MEM_WAIT_EN) mem_ready.
REQ-013 FETCH1 -> bit0; next FETCH2.
REQ-014 FETCH2 -> bits1|6; next FETCH3.
REQ-015 FETCH3 -> bit2; next DECODE.
REQ-016 DECODE, LOAD 0x02/ADD 0x03/SUB 0x04/STORE 0x01 -> bit3; next EXEC1.
REQ-017 DECODE, JMP 0x06 -> bit20; next FETCH1.
REQ-018 DECODE, JMPGEZ 0x05 -> bit20 only if acc_neg=0, else 0; next FETCH1.
REQ-019 DECODE, HALT 0x07 -> 0; next HALT. Any other opcode (incl. 0x00) -> 0 (NOP); next FETCH1.
REQ-020 EXEC1: LOAD/ADD/SUB -> bit1; STORE -> bit5; next EXEC2.
REQ-021 EXEC2: LOAD -> bit7; ADD -> bit8; SUB -> bit9; STORE -> bit4; next FETCH1.
REQ-022 Bits 6 and 20 SHALL never be asserted in the same cycle.
REQ-023 Latency: memory instructions 6 cycles, jumps/NOP 4 cycles, HALT 4 cycles to halted=1.
REQ-024 HALT SHALL drive control_signal=0, halted=1, and remain until reset.
REQ-025 Opcode SHALL be sampled from ir_in in DECODE, EXEC1, EXEC2; ir_in is stable in those states.

Reset
REQ-026 rst=1 SHALL force state FETCH1 immediately, independent of clk.
REQ-027 During and after reset: control_signal=32'h0000_0001, halted=0, state_dbg=FETCH1 encoding.
REQ-028 Reset mid-instruction (any state incl. HALT) SHALL abandon it; first post-reset edge enters FETCH2.

Configuration
REQ-029 Macro MEM_WAIT_EN SHALL enable memory wait states.
REQ-030 With MEM_WAIT_EN: FETCH2, EXEC1 (LOAD/ADD/SUB) and EXEC2 (STORE) SHALL hold while mem_ready=0, keeping their control bits, except bit6, which asserts only in the FETCH2 cycle with mem_ready=1 (exactly one PC increment per fetch).
REQ-031 Without MEM_WAIT_EN: mem_ready SHALL be ignored; timing per REQ-013..021.

Structure
REQ-032 Package cpu_pkg SHALL hold opcode constants, control-bit index constants and the state enum.
REQ-033 Sub-module seq_decode SHALL hold the combinational (state, opcode, acc_neg, mem_ready) -> control_signal decode; cpu_sequencer holds only the state register and next-state logic.

Verification
REQ-034 Reset then ir_in=16'h0210 (LOAD 0x10) -> control_signal 0x1,0x42,0x4,0x8,0x2,0x80, then 0x1; PC+1 exactly once.
REQ-035 ir_in=16'h0635 (JMP) -> DECODE cycle control_signal=0x0010_0000; FETCH1 next.
REQ-036 ir_in=16'h0540, acc_neg=1 -> DECODE control_signal=0; repeat with acc_neg=0 -> 0x0010_0000.
REQ-037 ir_in=16'h0700 -> halted=1 in 4th cycle, control_signal=0 for 20 cycles; rst pulse -> FETCH1, halted=0.
REQ-038 MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH2 -> bit1 held 4 cycles, bit6 only in final cycle.
REQ-039 rst asserted asynchronously mid-EXEC1 of ADD -> control_signal=0x1 before next edge; bits 8/9 never asserted.
